// File: rtl/xxhash32_pkg.sv
// Shared constants, state encoding and arithmetic helpers for the xxHash32 engine.
// Rotations take constant amounts at every call site, so they reduce to wiring.
package xxhash32_pkg;

  localparam int unsigned WORD_SIZE = 32;

  localparam logic [31:0] P1 = 32'h9E3779B1;
  localparam logic [31:0] P2 = 32'h85EBCA77;
  localparam logic [31:0] P3 = 32'hC2B2AE3D;
  localparam logic [31:0] P4 = 32'h27D4EB2F;
  localparam logic [31:0] P5 = 32'h165667B1;

  typedef enum logic [2:0] {IDLE, ACCUM, FIN1, FIN2, DONE} state_t;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned r);
    return (x << r) | (x >> (32 - r));
  endfunction

  // Absorbs one buffered tail word into the finalization hash.
  function automatic logic [31:0] tail_step(input logic [31:0] h, input logic [31:0] w);
    return rotl(h + w * P3, 17) * P4;
  endfunction

  function automatic logic [31:0] avalanche(input logic [31:0] x);
    logic [31:0] h;
    h = x ^ (x >> 15);
    h = h * P2;
    h = h ^ (h >> 13);
    h = h * P3;
    h = h ^ (h >> 16);
    return h;
  endfunction

endpackage

// File: rtl/xxhash32_round.sv
// Combinational xxHash32 lane round: rotl(acc + word*P2, 13) * P1.
module xxhash32_round
  import xxhash32_pkg::*;
(
  input  logic [WORD_SIZE-1:0] acc,
  input  logic [WORD_SIZE-1:0] word,
  output logic [WORD_SIZE-1:0] result
);

  logic [31:0] sum;

  assign sum    = acc + word * P2;
  assign result = rotl(sum, 13) * P1;

endmodule

// File: rtl/xxhash32.sv
// Streaming xxHash32: absorbs one little-endian 32-bit word per cycle and finalizes in
// two cycles (stripe merge + length, then tail words + avalanche).
module xxhash32 #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 seed_in,
  input  logic                 add_to_hash,
  input  logic                 request_hash,
  input  logic [WORD_SIZE-1:0] input_bytes,
  output logic                 hash_ready,
  output logic [WORD_SIZE-1:0] output_hash
);

  import xxhash32_pkg::*;

  state_t      state_q;
  logic [31:0] seed_q, v1_q, v2_q, v3_q, v4_q;
  logic [31:0] count_q, h_q, out_q;
  logic [31:0] buf0_q, buf1_q, buf2_q;
  logic [1:0]  lane_q;
  logic        stripe_q, ready_q;

  logic [31:0] r1, r2, r3, r4;
  logic [31:0] fin1, tail;
  logic        absorb;

  // Lane 3 completes a stripe straight from input_bytes, so only three words are buffered.
  xxhash32_round u_round1 (.acc(v1_q), .word(buf0_q),      .result(r1));
  xxhash32_round u_round2 (.acc(v2_q), .word(buf1_q),      .result(r2));
  xxhash32_round u_round3 (.acc(v3_q), .word(buf2_q),      .result(r3));
  xxhash32_round u_round4 (.acc(v4_q), .word(input_bytes), .result(r4));

  assign absorb = add_to_hash && (state_q != FIN1) && (state_q != FIN2);

  always_comb begin
    if (stripe_q) begin
      fin1 = rotl(v1_q, 1) + rotl(v2_q, 7) + rotl(v3_q, 12) + rotl(v4_q, 18);
    end else begin
      fin1 = seed_q + P5;
    end
    fin1 = fin1 + (count_q << 2);

    tail = h_q;
    if (lane_q != 2'd0) tail = tail_step(tail, buf0_q);
    if (lane_q >= 2'd2) tail = tail_step(tail, buf1_q);
    if (lane_q == 2'd3) tail = tail_step(tail, buf2_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      seed_q   <= '0;
      v1_q     <= '0;
      v2_q     <= '0;
      v3_q     <= '0;
      v4_q     <= '0;
      count_q  <= '0;
      h_q      <= '0;
      out_q    <= '0;
      buf0_q   <= '0;
      buf1_q   <= '0;
      buf2_q   <= '0;
      lane_q   <= '0;
      stripe_q <= 1'b0;
      ready_q  <= 1'b0;
    end else if (seed_in) begin
      seed_q   <= input_bytes;
      v1_q     <= input_bytes + P1 + P2;
      v2_q     <= input_bytes + P2;
      v3_q     <= input_bytes;
      v4_q     <= input_bytes - P1;
      count_q  <= '0;
      buf0_q   <= '0;
      buf1_q   <= '0;
      buf2_q   <= '0;
      lane_q   <= '0;
      stripe_q <= 1'b0;
      ready_q  <= 1'b0;
      state_q  <= ACCUM;
    end else if (absorb) begin
      ready_q <= 1'b0;
      state_q <= ACCUM;
      if (state_q == IDLE) begin
        // No seed was given: start an implicit seed-0 hash with this as the first word.
        seed_q  <= '0;
        v1_q    <= P1 + P2;
        v2_q    <= P2;
        v3_q    <= '0;
        v4_q    <= 32'd0 - P1;
        buf0_q  <= input_bytes;
        lane_q  <= 2'd1;
        count_q <= 32'd1;
      end else begin
        count_q <= count_q + 32'd1;
        lane_q  <= lane_q + 2'd1;
        case (lane_q)
          2'd0: buf0_q <= input_bytes;
          2'd1: buf1_q <= input_bytes;
          2'd2: buf2_q <= input_bytes;
          default: begin
            v1_q     <= r1;
            v2_q     <= r2;
            v3_q     <= r3;
            v4_q     <= r4;
            stripe_q <= 1'b1;
          end
        endcase
      end
    end else begin
      unique case (state_q)
        ACCUM: if (request_hash) state_q <= FIN1;
        FIN1: begin
          h_q     <= fin1;
          state_q <= FIN2;
        end
        FIN2: begin
          out_q   <= avalanche(tail);
          ready_q <= 1'b1;
          state_q <= DONE;
        end
        IDLE, DONE: ;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hash_ready  = ready_q;
  assign output_hash = out_q;

endmodule

// File: tb/tb_xxhash32.sv
// Scoreboard bench for xxhash32: a byte-oriented software XXH32 model predicts each digest.
module tb_xxhash32;

  localparam logic [31:0] Q1 = 32'h9E3779B1;
  localparam logic [31:0] Q2 = 32'h85EBCA77;
  localparam logic [31:0] Q3 = 32'hC2B2AE3D;
  localparam logic [31:0] Q4 = 32'h27D4EB2F;
  localparam logic [31:0] Q5 = 32'h165667B1;

  logic        clk, rst_n, seed_in, add_to_hash, request_hash, hash_ready;
  logic [31:0] input_bytes, output_hash;

  int          errors, checks;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [31:0] msg[$];
  logic [31:0] cur_seed, rng, last_exp;
  logic        prev_ready;

  xxhash32 #(.WORD_SIZE(32)) dut (
    .clk(clk), .rst_n(rst_n), .seed_in(seed_in), .add_to_hash(add_to_hash),
    .request_hash(request_hash), .input_bytes(input_bytes), .hash_ready(hash_ready),
    .output_hash(output_hash)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rl(input logic [31:0] x, input int r);
    return (x << r) | (x >> (32 - r));
  endfunction

  function automatic logic [31:0] rd32(input logic [7:0] b[$], input int p);
    return {b[p+3], b[p+2], b[p+1], b[p]};
  endfunction

  function automatic logic [31:0] lane_rnd(input logic [31:0] a, input logic [31:0] w);
    return rl(a + w * Q2, 13) * Q1;
  endfunction

  function automatic logic [31:0] ref_xxh32(input logic [31:0] m[$], input logic [31:0] seed);
    logic [7:0]  b[$];
    logic [31:0] a1, a2, a3, a4, h, w;
    int          len, p;
    foreach (m[i]) begin
      w = m[i];
      b.push_back(w[7:0]);
      b.push_back(w[15:8]);
      b.push_back(w[23:16]);
      b.push_back(w[31:24]);
    end
    len = b.size();
    p   = 0;
    if (len >= 16) begin
      a1 = seed + Q1 + Q2;
      a2 = seed + Q2;
      a3 = seed;
      a4 = seed - Q1;
      while (p + 16 <= len) begin
        a1 = lane_rnd(a1, rd32(b, p));
        a2 = lane_rnd(a2, rd32(b, p + 4));
        a3 = lane_rnd(a3, rd32(b, p + 8));
        a4 = lane_rnd(a4, rd32(b, p + 12));
        p += 16;
      end
      h = rl(a1, 1) + rl(a2, 7) + rl(a3, 12) + rl(a4, 18);
    end else begin
      h = seed + Q5;
    end
    h = h + 32'(len);
    while (p + 4 <= len) begin
      h = rl(h + rd32(b, p) * Q3, 17) * Q4;
      p += 4;
    end
    while (p < len) begin
      h = rl(h + {24'd0, b[p]} * Q5, 11) * Q1;
      p += 1;
    end
    h = h ^ (h >> 15);
    h = h * Q2;
    h = h ^ (h >> 13);
    h = h * Q3;
    h = h ^ (h >> 16);
    return h;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, req);
    end
  endtask

  // Monitor: each new assertion of hash_ready pops one expected digest.
  initial prev_ready = 1'b0;
  always @(negedge clk) begin
    if (hash_ready === 1'b1 && prev_ready !== 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_digest: got %08h expected none", output_hash);
      end else begin
        check(name_q.pop_front(), output_hash, exp_q.pop_front());
      end
    end
    prev_ready = hash_ready;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] next_word();
    rng = rng * 32'd1664525 + 32'd1013904223;
    return rng;
  endfunction

  task automatic send_seed(input logic [31:0] s);
    msg.delete();
    cur_seed    = s;
    seed_in     = 1'b1;
    input_bytes = s;
    step();
    seed_in = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    msg.push_back(w);
    add_to_hash = 1'b1;
    input_bytes = w;
    step();
    add_to_hash = 1'b0;
  endtask

  task automatic finish_case(input string name, input logic [31:0] expv);
    last_exp = expv;
    exp_q.push_back(expv);
    name_q.push_back(name);
    request_hash = 1'b1;
    step();
    request_hash = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check({name, "_ready_by_2"}, {31'd0, hash_ready}, 32'd1);
    step();
  endtask

  initial begin
    int n_tab[5] = '{1, 3, 4, 5, 16};
    errors = 0;
    checks = 0;
    rng    = 32'h12345678;
    rst_n = 1'b0; seed_in = 1'b0; add_to_hash = 1'b0; request_hash = 1'b0;
    input_bytes = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready", {31'd0, hash_ready}, 32'd0);
    check("reset_hash", output_hash, 32'd0);
    rst_n = 1'b1;
    step();

    // Words with no seed: implicit seed 0.
    cur_seed = 32'd0;
    msg.delete();
    send_word(32'h03020100);
    send_word(32'h07060504);
    finish_case("idle_add", ref_xxh32(msg, 32'd0));

    send_seed(32'd0);
    finish_case("empty_seed0", 32'h02CC5D05);

    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 5; k++) begin
        send_seed(s == 0 ? 32'd0 : 32'h9E3779B1);
        for (int i = 0; i < n_tab[k]; i++) send_word(next_word());
        finish_case($sformatf("seed%0d_n%0d", s, n_tab[k]), ref_xxh32(msg, cur_seed));
      end
    end

    // seed_in wins over add_to_hash: the word is dropped.
    msg.delete();
    cur_seed    = 32'hCAFEF00D;
    seed_in     = 1'b1;
    add_to_hash = 1'b1;
    input_bytes = cur_seed;
    step();
    seed_in = 1'b0;
    add_to_hash = 1'b0;
    for (int i = 0; i < 5; i++) send_word(next_word());
    finish_case("seed_add_conflict", ref_xxh32(msg, cur_seed));

    // add_to_hash in DONE continues the same message.
    send_seed(32'h00000042);
    for (int i = 0; i < 2; i++) send_word(next_word());
    finish_case("cont_part1", ref_xxh32(msg, cur_seed));
    for (int i = 0; i < 5; i++) send_word(next_word());
    finish_case("cont_part2", ref_xxh32(msg, cur_seed));

    // request_hash held in DONE must not disturb the result.
    request_hash = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("hold_hash_%0d", i), output_hash, last_exp);
      check($sformatf("hold_ready_%0d", i), {31'd0, hash_ready}, 32'd1);
    end
    step();
    request_hash = 1'b0;

    // Reset mid-message abandons the hash.
    send_seed(32'h11111111);
    for (int i = 0; i < 6; i++) send_word(next_word());
    rst_n = 1'b0;
    #2;
    check("midreset_ready", {31'd0, hash_ready}, 32'd0);
    check("midreset_hash", output_hash, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    send_seed(32'h22222222);
    for (int i = 0; i < 7; i++) send_word(next_word());
    finish_case("after_reset", ref_xxh32(msg, cur_seed));

    repeat (3) step();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL pending_digests: got %0d outstanding expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
